// File: rtl/alu_seq_pkg.sv
// Shared types and widths for the ALU command sequencer: opcodes, FSM states, flag bundle.
package alu_seq_pkg;

  localparam int unsigned OPND_W = 4;
  localparam int unsigned RES_W  = 5;
  localparam int unsigned OP_W   = 2;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    StIdle,
    StPresel,
    StWait,
    StResp
  } state_e;

  typedef struct packed {
    logic zero;
    logic sign;
    logic carry;
    logic ovf;
  } flags_t;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Command, ALU-side and response signals of the sequencer, with the sequencer as master
// and the surrounding environment (command source, ALU, response sink) as slave.
interface alu_op_sequencer_if;
  import alu_seq_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [OPND_W-1:0] cmd_a;
  logic [OPND_W-1:0] cmd_b;
  logic [OP_W-1:0]   cmd_op;
  logic [OPND_W-1:0] alu_ea;
  logic [OPND_W-1:0] alu_eb;
  logic [OP_W-1:0]   alu_op;
  logic [RES_W-1:0]  alu_saida;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [RES_W-1:0]  rsp_result;
  logic [OP_W-1:0]   rsp_op;
  logic              flag_zero;
  logic              flag_sign;
  logic              flag_carry;
  logic              flag_ovf;
  logic              busy;

  modport master (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, alu_saida, rsp_ready,
    output cmd_ready, alu_ea, alu_eb, alu_op, rsp_valid, rsp_result, rsp_op,
    output flag_zero, flag_sign, flag_carry, flag_ovf, busy
  );

  modport slave (
    output cmd_valid, cmd_a, cmd_b, cmd_op, alu_saida, rsp_ready,
    input  cmd_ready, alu_ea, alu_eb, alu_op, rsp_valid, rsp_result, rsp_op,
    input  flag_zero, flag_sign, flag_carry, flag_ovf, busy
  );

endinterface

// File: rtl/alu_flag_calc.sv
// Combinational status flags from operands, opcode and ALU result.
// Only compiled when ALU_SEQ_FLAGS_EN is defined.
`ifdef ALU_SEQ_FLAGS_EN
module alu_flag_calc
  import alu_seq_pkg::*;
(
  input  logic [OPND_W-1:0] a,
  input  logic [OPND_W-1:0] b,
  input  logic [OP_W-1:0]   op,
  input  logic [RES_W-1:0]  result,
  output flags_t            flags
);

  localparam int unsigned Msb = OPND_W - 1;

  always_comb begin
    flags       = '0;
    flags.zero  = (result[Msb:0] == '0);
    flags.sign  = result[Msb];
    flags.carry = result[RES_W-1];
    case (op)
      OP_ADD:  flags.ovf = (a[Msb] == b[Msb]) && (result[Msb] != a[Msb]);
      OP_SUB:  flags.ovf = (a[Msb] != b[Msb]) && (result[Msb] != a[Msb]);
      default: flags.ovf = 1'b0;
    endcase
  end

endmodule
`endif

// File: rtl/alu_op_sequencer.sv
// Sequencer driving the 4-bit enable-triggered ALU: accept, pre-select, settle, respond.
// Optional status flags are built when ALU_SEQ_FLAGS_EN is defined; otherwise tied to 0.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input logic              clk,
  input logic              rst_n,
  alu_op_sequencer_if.master bus
);

  localparam int unsigned CntW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [OPND_W-1:0] ea_q, ea_d, eb_q, eb_d;
  logic [OP_W-1:0]   alu_op_q, alu_op_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [RES_W-1:0]  result_q, result_d;
  logic [OP_W-1:0]   rsp_op_q, rsp_op_d;
  logic              busy_q, busy_d;
  logic              capture;

  assign capture = (state_q == StWait) && (cnt_q == '0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    ea_d        = ea_q;
    eb_d        = eb_q;
    alu_op_d    = alu_op_q;
    cmd_ready_d = 1'b0;
    rsp_valid_d = rsp_valid_q;
    result_d    = result_q;
    rsp_op_d    = rsp_op_q;
    unique case (state_q)
      StIdle: begin
        cmd_ready_d = 1'b1;
        if (bus.cmd_valid && cmd_ready_q) begin
          ea_d        = bus.cmd_a;
          eb_d        = bus.cmd_b;
          op_d        = bus.cmd_op;
          // Park on a different unit so the real one sees a fresh enable edge next cycle.
          alu_op_d    = bus.cmd_op ^ OP_W'(1);
          cmd_ready_d = 1'b0;
          state_d     = StPresel;
        end
      end
      StPresel: begin
        alu_op_d = op_q;
        cnt_d    = CntW'(SETTLE_CYCLES - 1);
        state_d  = StWait;
      end
      StWait: begin
        if (capture) begin
          result_d    = bus.alu_saida;
          rsp_op_d    = op_q;
          rsp_valid_d = 1'b1;
          state_d     = StResp;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StResp: begin
        if (rsp_valid_q && bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      op_q        <= '0;
      ea_q        <= '0;
      eb_q        <= '0;
      alu_op_q    <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      result_q    <= '0;
      rsp_op_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      ea_q        <= ea_d;
      eb_q        <= eb_d;
      alu_op_q    <= alu_op_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      result_q    <= result_d;
      rsp_op_q    <= rsp_op_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.alu_ea     = ea_q;
  assign bus.alu_eb     = eb_q;
  assign bus.alu_op     = alu_op_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = result_q;
  assign bus.rsp_op     = rsp_op_q;
  assign bus.busy       = busy_q;

`ifdef ALU_SEQ_FLAGS_EN
  flags_t flags_calc, flags_q;

  alu_flag_calc u_flag_calc (
    .a      (ea_q),
    .b      (eb_q),
    .op     (op_q),
    .result (bus.alu_saida),
    .flags  (flags_calc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else if (capture) begin
      flags_q <= flags_calc;
    end
  end

  assign bus.flag_zero  = flags_q.zero;
  assign bus.flag_sign  = flags_q.sign;
  assign bus.flag_carry = flags_q.carry;
  assign bus.flag_ovf   = flags_q.ovf;
`else
  assign bus.flag_zero  = 1'b0;
  assign bus.flag_sign  = 1'b0;
  assign bus.flag_carry = 1'b0;
  assign bus.flag_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer with a behavioural enable-triggered ALU and an arithmetic model.
module tb_alu_op_sequencer;

  localparam int S = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  alu_op_sequencer_if bus ();

  alu_op_sequencer #(.SETTLE_CYCLES(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  // ALU: each unit re-evaluates only when its enable (opcode decode) newly rises.
  logic [4:0] unit_res [4] = '{default: 5'd0};
  logic [1:0] seen_op = 2'b00;

  always @(negedge clk) begin
    if (bus.alu_op !== seen_op) begin
      case (bus.alu_op)
        2'b00:   unit_res[0] <= {1'b0, bus.alu_ea} + {1'b0, bus.alu_eb};
        2'b01:   unit_res[1] <= {1'b0, bus.alu_ea} - {1'b0, bus.alu_eb};
        2'b10:   unit_res[2] <= {1'b0, bus.alu_ea & bus.alu_eb};
        default: unit_res[3] <= {1'b0, bus.alu_ea | bus.alu_eb};
      endcase
      seen_op <= bus.alu_op;
    end
  end

  assign bus.alu_saida = unit_res[bus.alu_op];

  function automatic logic [4:0] model_result(input int op, input int a, input int b);
    int r;
    case (op)
      0:       r = a + b;
      1:       r = (a - b + 32) % 32;
      2:       r = a & b;
      default: r = a | b;
    endcase
    return 5'(r);
  endfunction

  // Returns {zero, sign, carry, ovf}.
  function automatic logic [3:0] model_flags(input int op, input int a, input int b);
`ifdef ALU_SEQ_FLAGS_EN
    int r, sa, sb, s;
    logic ovf;
    r   = int'(model_result(op, a, b));
    sa  = (a > 7) ? a - 16 : a;
    sb  = (b > 7) ? b - 16 : b;
    s   = (op == 0) ? sa + sb : sa - sb;
    ovf = (op < 2) && (s > 7 || s < -8);
    return {(r % 16) == 0, ((r / 8) % 2) == 1, (r / 16) == 1, ovf};
`else
    return 4'b0000;
`endif
  endfunction

  function automatic logic [3:0] dut_flags();
    return {bus.flag_zero, bus.flag_sign, bus.flag_carry, bus.flag_ovf};
  endfunction

  // Presents one command; returns idle cycles before acceptance and edges until rsp_valid.
  task automatic issue(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                       output int acc_wait, output int lat);
    acc_wait = -1;
    lat = -1;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_a = a;
    bus.cmd_b = b;
    bus.cmd_op = op;
    for (int i = 0; i < 20; i++) begin
      if (bus.cmd_ready) begin
        acc_wait = i;
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    if (acc_wait < 0) return;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (bus.rsp_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [23:0] outs;
    #12;
    outs = {bus.cmd_ready, bus.alu_ea, bus.alu_eb, bus.alu_op, bus.rsp_valid, bus.rsp_result,
            bus.rsp_op, dut_flags(), bus.busy};
    checks++;
    if (outs !== 24'd0) begin
      failures++;
      $display("FAIL reset_outputs: got %h want 0", outs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL ready_before_edge: got %b want 0", bus.cmd_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_reset: got %b want 1", bus.cmd_ready);
    end
  endtask

  // Runs one op with rsp_ready high and checks result, opcode, flags, latency and release.
  task automatic run_checked(input string name, input logic [1:0] op, input logic [3:0] a,
                             input logic [3:0] b, input int want_wait);
    int acc_wait, lat;
    logic [4:0] want_res;
    logic [3:0] want_flags;
    want_res = model_result(int'(op), int'(a), int'(b));
    want_flags = model_flags(int'(op), int'(a), int'(b));
    bus.rsp_ready = 1'b1;
    issue(op, a, b, acc_wait, lat);
    checks++;
    if (lat !== 1 + S) begin
      failures++;
      $display("FAIL %s_latency: got %0d want %0d", name, lat, 1 + S);
    end
    checks++;
    if (bus.rsp_result !== want_res) begin
      failures++;
      $display("FAIL %s_result: got %b want %b", name, bus.rsp_result, want_res);
    end
    checks++;
    if (bus.rsp_op !== op) begin
      failures++;
      $display("FAIL %s_rsp_op: got %b want %b", name, bus.rsp_op, op);
    end
    checks++;
    if (dut_flags() !== want_flags) begin
      failures++;
      $display("FAIL %s_flags: got %b want %b", name, dut_flags(), want_flags);
    end
    if (want_wait >= 0) begin
      checks++;
      if (acc_wait !== want_wait) begin
        failures++;
        $display("FAIL %s_accept_wait: got %0d want %0d", name, acc_wait, want_wait);
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if ({bus.rsp_valid, bus.cmd_ready, bus.busy} !== 3'b010) begin
      failures++;
      $display("FAIL %s_release: got valid/ready/busy %b want 010", name,
               {bus.rsp_valid, bus.cmd_ready, bus.busy});
    end
  endtask

  task automatic test_directed();
    run_checked("add_5_3", 2'b00, 4'd5, 4'd3, 0);
    checks++;
    if (model_result(0, 5, 3) !== 5'b01000 || bus.rsp_result !== 5'b01000) begin
      failures++;
      $display("FAIL add_5_3_literal: got %b want 01000", bus.rsp_result);
    end
    run_checked("sub_3_5", 2'b01, 4'd3, 4'd5, 0);
    checks++;
    if (bus.rsp_result !== 5'b11110) begin
      failures++;
      $display("FAIL sub_3_5_literal: got %b want 11110", bus.rsp_result);
    end
    run_checked("sub_5_3", 2'b01, 4'd5, 4'd3, 0);
    run_checked("and_5_3", 2'b10, 4'd5, 4'd3, 0);
    run_checked("or_5_3", 2'b11, 4'd5, 4'd3, 0);
  endtask

  task automatic test_back_to_back();
    run_checked("b2b_first", 2'b00, 4'd5, 4'd3, 0);
    run_checked("b2b_second", 2'b00, 4'd1, 4'd1, 0);
    checks++;
    if (bus.rsp_result !== 5'b00010) begin
      failures++;
      $display("FAIL b2b_stale: got %b want 00010", bus.rsp_result);
    end
    run_checked("b2b_sub_same", 2'b01, 4'd9, 4'd2, 0);
    run_checked("b2b_sub_again", 2'b01, 4'd2, 4'd9, 0);
  endtask

  task automatic test_random();
    logic [1:0] op;
    logic [3:0] a, b;
    for (int n = 0; n < 24; n++) begin
      op = 2'($urandom_range(0, 3));
      a  = 4'($urandom_range(0, 15));
      b  = 4'($urandom_range(0, 15));
      run_checked("rand", op, a, b, 0);
    end
  endtask

  task automatic test_backpressure();
    int acc_wait, lat;
    logic [4:0] held_res;
    logic [3:0] held_flags;
    logic [7:0] want_held;
    bus.rsp_ready = 1'b0;
    issue(2'b00, 4'd7, 4'd2, acc_wait, lat);
    checks++;
    if (lat !== 1 + S) begin
      failures++;
      $display("FAIL bp_latency: got %0d want %0d", lat, 1 + S);
    end
    held_res = bus.rsp_result;
    held_flags = dut_flags();
    want_held = {1'b1, 1'b0, 1'b1, model_result(0, 7, 2)};
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      bus.cmd_valid = (c == 1);
      bus.cmd_a = 4'hf;
      bus.cmd_b = 4'hf;
      bus.cmd_op = 2'b11;
      @(posedge clk);
      #1;
      checks++;
      if ({bus.rsp_valid, bus.cmd_ready, bus.busy, bus.rsp_result} !== want_held ||
          dut_flags() !== held_flags || held_flags !== model_flags(0, 7, 2)) begin
        failures++;
        $display("FAIL bp_hold: got valid/ready/busy/res %b flags %b want %b flags %b",
                 {bus.rsp_valid, bus.cmd_ready, bus.busy, bus.rsp_result}, dut_flags(),
                 want_held, model_flags(0, 7, 2));
      end
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({bus.rsp_valid, bus.cmd_ready, bus.alu_ea, bus.alu_op} !== {1'b0, 1'b1, 4'd7, 2'b00}) begin
      failures++;
      $display("FAIL bp_release: got valid/ready/ea/op %b want 01011100",
               {bus.rsp_valid, bus.cmd_ready, bus.alu_ea, bus.alu_op});
    end
    checks++;
    if (held_res !== 5'b01001) begin
      failures++;
      $display("FAIL bp_result: got %b want 01001", held_res);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [23:0] outs;
    bit seen_rsp;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_a = 4'd9;
    bus.cmd_b = 4'd6;
    bus.cmd_op = 2'b00;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({bus.busy, bus.alu_ea, bus.rsp_valid} !== {1'b1, 4'd9, 1'b0}) begin
      failures++;
      $display("FAIL midop_in_wait: got busy/ea/valid %b want 110010",
               {bus.busy, bus.alu_ea, bus.rsp_valid});
    end
    #2;
    rst_n = 1'b0;
    #1;
    outs = {bus.cmd_ready, bus.alu_ea, bus.alu_eb, bus.alu_op, bus.rsp_valid, bus.rsp_result,
            bus.rsp_op, dut_flags(), bus.busy};
    checks++;
    if (outs !== 24'd0) begin
      failures++;
      $display("FAIL midop_async_clear: got %h want 0", outs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL midop_ready: got %b want 1", bus.cmd_ready);
    end
    seen_rsp = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) seen_rsp = 1'b1;
    end
    checks++;
    if (seen_rsp) begin
      failures++;
      $display("FAIL midop_no_response: got activity 1 want 0");
    end
    run_checked("after_reset", 2'b01, 4'd4, 4'd4, 0);
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_a = '0;
    bus.cmd_b = '0;
    bus.cmd_op = '0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
